// File: rtl/approx_add_err_monitor.sv
// Exhaustive error monitor for a 4-bit approximate adder: sweeps every operand
// vector, compares the returned {cout,sum} with the exact sum and accumulates
// error statistics. Define CIN_SWEEP_EN to also sweep carry-in (512 vectors).
module approx_add_err_monitor #(
  parameter int unsigned N2 = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       cin,
  input  logic [3:0] sum,
  input  logic       cout,
  output logic       busy,
  output logic       done,
  output logic [9:0] err_cnt,
  output logic [4:0] max_ed,
  output logic [13:0] sum_ed,
  output logic       first_err_vld,
  output logic [8:0] first_err_idx,
  output logic [2:0] cfg_n2
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

`ifdef CIN_SWEEP_EN
  localparam logic [8:0] LAST_V = 9'd511;
`else
  localparam logic [8:0] LAST_V = 9'd255;
`endif

  state_t     state;
  logic [8:0] v;
  logic [4:0] exact5;
  logic [4:0] approx5;
  logic [4:0] ed;

  assign cfg_n2 = N2[2:0];

  // Operands come straight from the vector counter and read 0 outside a sweep.
  assign a = (state == SWEEP) ? v[7:4] : 4'd0;
  assign b = (state == SWEEP) ? v[3:0] : 4'd0;
`ifdef CIN_SWEEP_EN
  assign cin = (state == SWEEP) ? v[8] : 1'b0;
`else
  assign cin = 1'b0;
`endif

  assign exact5  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
  assign approx5 = {cout, sum};
  assign ed      = (exact5 >= approx5) ? (exact5 - approx5) : (approx5 - exact5);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      v             <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_cnt       <= '0;
      max_ed        <= '0;
      sum_ed        <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= SWEEP;
            v             <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            err_cnt       <= '0;
            max_ed        <= '0;
            sum_ed        <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
          end
        end
        SWEEP: begin
          if (ed != 5'd0) begin
            err_cnt <= err_cnt + 10'd1;
            sum_ed  <= sum_ed + {9'd0, ed};
            if (ed > max_ed) max_ed <= ed;
            if (!first_err_vld) begin
              first_err_vld <= 1'b1;
              first_err_idx <= v;
            end
          end
          if (v == LAST_V) begin
            state <= DONE;
            v     <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            v <= v + 9'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_add_err_monitor.sv
// Directed bench for approx_add_err_monitor using a behavioural adder whose
// fault mode is selectable; expectations follow the CIN_SWEEP_EN build.
module tb_approx_add_err_monitor;

`ifdef CIN_SWEEP_EN
  localparam int VEC       = 512;
  localparam int STUCK_ERR = 511;
  localparam int STUCK_MAX = 31;
  localparam int STUCK_SUM = 7936;
`else
  localparam int VEC       = 256;
  localparam int STUCK_ERR = 255;
  localparam int STUCK_MAX = 30;
  localparam int STUCK_SUM = 3840;
`endif
  localparam int BUDGET = VEC + 100;

  localparam int M_EXACT = 0;
  localparam int M_STUCK = 1;
  localparam int M_INV0  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  a, b, sum;
  logic        cin, cout, busy, done, first_err_vld;
  logic [9:0]  err_cnt;
  logic [4:0]  max_ed;
  logic [13:0] sum_ed;
  logic [8:0]  first_err_idx;
  logic [2:0]  cfg_n2;

  int mode = M_EXACT;
  int total = 0;
  int bad = 0;
  logic [4:0] ex;

  always #5 clk = ~clk;

  always_comb begin
    ex = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    case (mode)
      M_STUCK: {cout, sum} = 5'd0;
      M_INV0:  {cout, sum} = {ex[4:1], ~ex[0]};
      default: {cout, sum} = ex;
    endcase
  end

  approx_add_err_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .busy(busy), .done(done), .err_cnt(err_cnt),
    .max_ed(max_ed), .sum_ed(sum_ed), .first_err_vld(first_err_vld),
    .first_err_idx(first_err_idx), .cfg_n2(cfg_n2)
  );

  // Pulses start, then counts edges until done; start can be re-asserted so
  // that it is sampled on edge mid_start+1.
  task automatic run_sweep(input int mid_start, output int cycles);
    cycles = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL sweep_entry: busy=%b done=%b want busy=1 done=0", busy, done);
    end
    while (done !== 1'b1 && cycles < BUDGET) begin
      @(posedge clk); #1;
      cycles++;
      start = (cycles == mid_start);
      if (cycles == 37) begin
        total++;
        if ({a, b, cin} !== {4'd2, 4'd5, 1'b0}) begin
          bad++; $display("FAIL operands_v37: a=%0d b=%0d cin=%b want a=2 b=5 cin=0", a, b, cin);
        end
      end
    end
    start = 1'b0;
    total++;
    if (cycles != VEC) begin
      bad++; $display("FAIL sweep_len: cycles=%0d want %0d", cycles, VEC);
    end
  endtask

  task automatic check_results(input string tag, input int e_err, input int e_max,
                               input int e_sum, input logic e_vld, input int e_idx);
    total++;
    if (err_cnt !== 10'(e_err) || max_ed !== 5'(e_max) || sum_ed !== 14'(e_sum)) begin
      bad++;
      $display("FAIL %s_stats: err_cnt=%0d max_ed=%0d sum_ed=%0d want %0d %0d %0d",
               tag, err_cnt, max_ed, sum_ed, e_err, e_max, e_sum);
    end
    total++;
    if (first_err_vld !== e_vld || first_err_idx !== 9'(e_idx)) begin
      bad++;
      $display("FAIL %s_first: vld=%b idx=%0d want vld=%b idx=%0d",
               tag, first_err_vld, first_err_idx, e_vld, e_idx);
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b1 || {a, b, cin} !== 9'd0) begin
      bad++;
      $display("FAIL %s_done_state: busy=%b done=%b a=%0d b=%0d cin=%b want 0 1 0 0 0",
               tag, busy, done, a, b, cin);
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({a, b, cin, busy, done, err_cnt, max_ed, sum_ed, first_err_vld, first_err_idx} !== 50'd0) begin
      bad++; $display("FAIL reset_outputs: got nonzero outputs err_cnt=%0d busy=%b done=%b", err_cnt, busy, done);
    end
    total++;
    if (cfg_n2 !== 3'd0) begin
      bad++; $display("FAIL cfg_n2: got %0d want 0", cfg_n2);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL idle_wait: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_exact();
    int cyc;
    mode = M_EXACT;
    run_sweep(-1, cyc);
    check_results("exact", 0, 0, 0, 1'b0, 0);
  endtask

  task automatic test_stuck();
    int cyc;
    mode = M_STUCK;
    run_sweep(-1, cyc);
    check_results("stuck", STUCK_ERR, STUCK_MAX, STUCK_SUM, 1'b1, 1);
  endtask

  task automatic test_invert();
    int cyc;
    mode = M_INV0;
    run_sweep(-1, cyc);
    check_results("invert", VEC, 1, VEC, 1'b1, 0);
  endtask

  task automatic test_mid_start();
    int cyc;
    mode = M_INV0;
    run_sweep(100, cyc);
    check_results("mid_start", VEC, 1, VEC, 1'b1, 0);
  endtask

  task automatic test_final_start();
    int cyc;
    mode = M_STUCK;
    run_sweep(VEC - 1, cyc);
    repeat (3) @(negedge clk);
    check_results("final_start", STUCK_ERR, STUCK_MAX, STUCK_SUM, 1'b1, 1);
  endtask

  task automatic test_back_to_back();
    int cyc;
    mode = M_EXACT;
    run_sweep(-1, cyc);
    check_results("restart", 0, 0, 0, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    int cyc;
    mode = M_STUCK;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (50) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({a, b, cin, busy, done, err_cnt, max_ed, sum_ed, first_err_vld, first_err_idx} !== 50'd0) begin
      bad++; $display("FAIL reset_mid: err_cnt=%0d sum_ed=%0d busy=%b vld=%b want all 0",
                      err_cnt, sum_ed, busy, first_err_vld);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || err_cnt !== 10'd0) begin
      bad++; $display("FAIL reset_idle: busy=%b done=%b err_cnt=%0d want 0 0 0", busy, done, err_cnt);
    end
    run_sweep(-1, cyc);
    check_results("after_reset", STUCK_ERR, STUCK_MAX, STUCK_SUM, 1'b1, 1);
  endtask

  initial begin
    test_reset();
    test_exact();
    test_stuck();
    test_invert();
    test_mid_start();
    test_final_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
